// File: rtl/rapcores_wb_spi_master.sv
`timescale 1ns/1ps
// rapcores_wb_spi_master
// Wishbone slave that lets the management SoC drive rapcore's SPI port. It
// sequences 64-bit SPI mode-0 frames (MSB first, SCK idles low, CS active-low)
// and captures CIPO into the RX registers.
//
// Ports
//   wb_clk_i, wb_rst_i        : system clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i      : Wishbone strobe, cycle, write enable
//   wbs_sel_i[3:0]            : byte-lane select, honoured on writes
//   wbs_adr_i[31:0]           : address, only [4:2] decoded
//   wbs_dat_i/wbs_dat_o[31:0] : write / read data
//   wbs_ack_o                 : single-cycle acknowledge
//   spi_sck_o, spi_cs_o       : SPI clock (idle low), chip select (active low)
//   spi_copi_o, spi_cipo_i    : SPI data out / data in
//   busy_o                    : frame in progress
//   irq_o                     : done & irq_en (level)
//
// Register map (adr[4:2]): 0 TX_LO, 1 TX_HI, 2 RX_LO, 3 RX_HI,
//   4 CTRL {irq_en[9], start[8], div[7:0]}, 5 STATUS {done[1] W1C, busy[0]}.
module rapcores_wb_spi_master #(
    parameter int WORD_W    = 64,
    parameter int CLK_DIV_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck_o,
    output logic        spi_cs_o,
    output logic        spi_copi_o,
    input  logic        spi_cipo_i,
    output logic        busy_o,
    output logic        irq_o
);

    localparam logic [6:0] FRAME_BITS = 7'(WORD_W);
    localparam logic [6:0] LAST_BIT   = 7'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Byte-lane merge of a Wishbone write into an existing 32-bit register.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    state_t               state_r, state_nxt_s;
    logic                 ack_r, busy_r, irq_r, done_r, irq_en_r, start_req_r;
    logic                 sck_r, cs_r, copi_r;
    logic                 sck_nxt_s, cs_nxt_s, copi_nxt_s, busy_nxt_s;
    logic [31:0]          dat_r, tx_lo_r, tx_hi_r, rx_lo_r, rx_hi_r;
    logic [CLK_DIV_W-1:0] div_r, div_cnt_r;
    logic [6:0]           bit_cnt_r;
    logic [WORD_W-1:0]    tx_sh_r, rx_sh_r;
    logic [31:0]          rd_data_s, ctrl_rd_s, ctrl_wr_s;
    logic [2:0]           reg_idx_s;
    logic                 valid_s, acc_s, wr_s, clr_done_s;
    logic                 tick_s, launch_s, rise_s, fall_s, finish_s, shift_s;
    logic                 adr_unused_s;

    assign valid_s      = wbs_cyc_i & wbs_stb_i;
    // Accept only when no ack is in flight: a held valid gets one ack per 2 cycles.
    assign acc_s        = valid_s & ~ack_r;
    assign wr_s         = acc_s & wbs_we_i;
    assign reg_idx_s    = wbs_adr_i[4:2];
    assign clr_done_s   = wr_s & (reg_idx_s == 3'd5) & wbs_sel_i[0] & wbs_dat_i[1];
    assign adr_unused_s = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // FSM event strobes; tick marks the last clock of a half period.
    assign tick_s   = (div_cnt_r == div_r);
    assign launch_s = (state_r == S_IDLE) & start_req_r;
    assign rise_s   = tick_s & (((state_r == S_SETUP)) |
                      ((state_r == S_SHIFT) & ~sck_r & (bit_cnt_r != FRAME_BITS)));
    assign fall_s   = tick_s & (state_r == S_SHIFT) & sck_r;
    // The last falling edge leaves the final bit on the line: no shift then.
    assign shift_s  = fall_s & (bit_cnt_r != LAST_BIT);
    assign finish_s = tick_s & (state_r == S_HOLD);

    // CTRL readback and the merged view of a CTRL write.
    always_comb begin
        ctrl_rd_s                  = 32'd0;
        ctrl_rd_s[CLK_DIV_W-1:0]   = div_r;
        ctrl_rd_s[9]               = irq_en_r;
        ctrl_wr_s                  = lane_merge(ctrl_rd_s, wbs_dat_i, wbs_sel_i);
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 32'd0;
        case (reg_idx_s)
            3'd0:    rd_data_s = tx_lo_r;
            3'd1:    rd_data_s = tx_hi_r;
            3'd2:    rd_data_s = rx_lo_r;
            3'd3:    rd_data_s = rx_hi_r;
            3'd4:    rd_data_s = ctrl_rd_s;
            3'd5:    rd_data_s = {30'd0, done_r, busy_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Wishbone handshake, register writes, done flag and interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r       <= 1'b0;
            dat_r       <= 32'd0;
            tx_lo_r     <= 32'd0;
            tx_hi_r     <= 32'd0;
            div_r       <= '0;
            irq_en_r    <= 1'b0;
            start_req_r <= 1'b0;
            done_r      <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            ack_r       <= acc_s;
            start_req_r <= 1'b0;
            irq_r       <= done_r & irq_en_r;
            if (acc_s && !wbs_we_i) begin
                dat_r <= rd_data_s;
            end
            if (wr_s) begin
                case (reg_idx_s)
                    3'd0: if (!busy_r) tx_lo_r <= lane_merge(tx_lo_r, wbs_dat_i, wbs_sel_i);
                    3'd1: if (!busy_r) tx_hi_r <= lane_merge(tx_hi_r, wbs_dat_i, wbs_sel_i);
                    3'd4: begin
                        irq_en_r <= ctrl_wr_s[9];
                        if (!busy_r) begin
                            div_r <= ctrl_wr_s[CLK_DIV_W-1:0];
                            if (wbs_sel_i[1] && wbs_dat_i[8] && (state_r == S_IDLE)) begin
                                start_req_r <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Hardware set beats a simultaneous software clear.
            if (finish_s) begin
                done_r <= 1'b1;
            end else if (clr_done_s) begin
                done_r <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (start_req_r) state_nxt_s = S_SETUP; else state_nxt_s = S_IDLE;
            S_SETUP: if (tick_s) state_nxt_s = S_SHIFT; else state_nxt_s = S_SETUP;
            S_SHIFT: if (tick_s && !sck_r && (bit_cnt_r == FRAME_BITS)) state_nxt_s = S_HOLD;
                     else state_nxt_s = S_SHIFT;
            S_HOLD:  if (tick_s) state_nxt_s = S_IDLE; else state_nxt_s = S_HOLD;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode: next values of the registered SPI pins and busy.
    always_comb begin
        sck_nxt_s  = sck_r;
        cs_nxt_s   = cs_r;
        copi_nxt_s = copi_r;
        busy_nxt_s = busy_r;
        if (launch_s) begin
            cs_nxt_s   = 1'b0;
            copi_nxt_s = tx_hi_r[31];
            busy_nxt_s = 1'b1;
        end else if (finish_s) begin
            cs_nxt_s   = 1'b1;
            copi_nxt_s = 1'b0;
            busy_nxt_s = 1'b0;
        end else if (rise_s) begin
            sck_nxt_s  = 1'b1;
        end else if (fall_s) begin
            sck_nxt_s  = 1'b0;
            if (shift_s) begin
                copi_nxt_s = tx_sh_r[WORD_W-2];
            end else begin
                copi_nxt_s = copi_r;
            end
        end else begin
            sck_nxt_s  = sck_r;
        end
    end

    // Shift datapath, counters and registered SPI pins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt_r <= '0;
            bit_cnt_r <= 7'd0;
            tx_sh_r   <= '0;
            rx_sh_r   <= '0;
            rx_lo_r   <= 32'd0;
            rx_hi_r   <= 32'd0;
            sck_r     <= 1'b0;
            cs_r      <= 1'b1;
            copi_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            sck_r  <= sck_nxt_s;
            cs_r   <= cs_nxt_s;
            copi_r <= copi_nxt_s;
            busy_r <= busy_nxt_s;
            if ((state_r == S_IDLE) || tick_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + 1'b1;
            end
            if (launch_s) begin
                tx_sh_r   <= {tx_hi_r, tx_lo_r};
                rx_sh_r   <= '0;
                bit_cnt_r <= 7'd0;
            end
            if (rise_s) begin
                rx_sh_r <= {rx_sh_r[WORD_W-2:0], spi_cipo_i};
            end
            if (fall_s) begin
                bit_cnt_r <= bit_cnt_r + 7'd1;
            end
            if (shift_s) begin
                tx_sh_r <= {tx_sh_r[WORD_W-2:0], 1'b0};
            end
            if (finish_s) begin
                rx_lo_r <= rx_sh_r[31:0];
                rx_hi_r <= rx_sh_r[63:32];
            end
        end
    end

    assign wbs_ack_o  = ack_r;
    assign wbs_dat_o  = dat_r;
    assign spi_sck_o  = sck_r;
    assign spi_cs_o   = cs_r;
    assign spi_copi_o = copi_r;
    assign busy_o     = busy_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_rapcores_wb_spi_master.sv
`timescale 1ns/1ps
module tb_rapcores_wb_spi_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        spi_sck_o, spi_cs_o, spi_copi_o, spi_cipo_i;
    logic        busy_o, irq_o;

    logic        loopback;
    logic        slave_cipo;

    int err_cnt = 0;
    int chk_cnt = 0;

    rapcores_wb_spi_master dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_copi_o (spi_copi_o),
        .spi_cipo_i (spi_cipo_i),
        .busy_o     (busy_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    assign spi_cipo_i = loopback ? spi_copi_o : slave_cipo;

    // Bus-level observer plus a rapcore-style mode-0 SPI slave.
    int          cyc_n = 0, busy_len = 0, rises = 0, frames_done = 0;
    int          cs_fall_cyc = 0, r1_cyc = 0, r2_cyc = 0;
    logic        pbusy = 1'b0, pcs = 1'b1, psck = 1'b0;
    logic [63:0] sl_word = 64'd0, sl_sh = 64'd0, sl_rx = 64'd0;

    always @(negedge wb_clk_i) begin
        cyc_n = cyc_n + 1;
        if (busy_o && !pbusy) begin
            busy_len = 1;
            rises    = 0;
        end else if (busy_o) begin
            busy_len = busy_len + 1;
        end
        if (pbusy && !busy_o) frames_done = frames_done + 1;
        if (!spi_cs_o && pcs) begin
            cs_fall_cyc = cyc_n;
            sl_sh       = sl_word;
            slave_cipo  = sl_word[63];
            sl_rx       = 64'd0;
        end
        if (spi_sck_o && !psck) begin
            rises = rises + 1;
            if (rises == 1) r1_cyc = cyc_n;
            if (rises == 2) r2_cyc = cyc_n;
            sl_rx = {sl_rx[62:0], spi_copi_o};
        end
        if (!spi_sck_o && psck) begin
            slave_cipo = sl_sh[62];
            sl_sh      = {sl_sh[62:0], 1'b0};
        end
        pbusy = busy_o;
        pcs   = spi_cs_o;
        psck  = spi_sck_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] sel);
        int n;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = {27'd0, idx, 2'b00}; wbs_dat_i = data; wbs_sel_i = sel;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!wbs_ack_o && n < 20);
        if (!wbs_ack_o) check("wr_ack_timeout", {63'd0, wbs_ack_o}, 64'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] data);
        int n;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = {27'd0, idx, 2'b00}; wbs_sel_i = 4'hF;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!wbs_ack_o && n < 20);
        if (!wbs_ack_o) check("rd_ack_timeout", {63'd0, wbs_ack_o}, 64'd1);
        data = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(idx, d);
        check(tag, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic wait_frame(input int base);
        int n;
        n = 0;
        while (frames_done == base && n < 5000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("frame_done", frames_done, base + 1);
        repeat (2) @(negedge wb_clk_i);
    endtask

    // Launch one frame and compare everything against the reference model.
    task automatic run_frame(input string tag, input logic [63:0] tx, input logic [7:0] div,
                             input logic lb, input logic [63:0] sw);
        int          h, base;
        logic [63:0] exp_rx;
        h        = int'(div) + 1;
        exp_rx   = lb ? tx : sw;
        loopback = lb;
        sl_word  = sw;
        wb_write(3'd0, tx[31:0], 4'hF);
        wb_write(3'd1, tx[63:32], 4'hF);
        base = frames_done;
        wb_write(3'd4, {22'd0, 1'b0, 1'b1, div}, 4'b0011);
        wait_frame(base);
        check({tag, "_busy_len"}, busy_len, 130 * h);
        check({tag, "_rises"}, rises, 64);
        check({tag, "_cs_to_rise"}, r1_cyc - cs_fall_cyc, h);
        check({tag, "_sck_period"}, r2_cyc - r1_cyc, 2 * h);
        if (!lb) check({tag, "_slave_rx"}, sl_rx, tx);
        read_check({tag, "_rx_lo"}, 3'd2, exp_rx[31:0]);
        read_check({tag, "_rx_hi"}, 3'd3, exp_rx[63:32]);
        read_check({tag, "_status"}, 3'd5, 32'd2);
    endtask

    initial begin
        logic [63:0] tx;
        logic [31:0] d;
        int          base, acks, n;

        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
        loopback = 1'b1; slave_cipo = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_cs", {63'd0, spi_cs_o}, 64'd1);
        check("rst_sck", {63'd0, spi_sck_o}, 64'd0);
        check("rst_copi", {63'd0, spi_copi_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_irq", {63'd0, irq_o}, 64'd0);
        check("rst_ack", {63'd0, wbs_ack_o}, 64'd0);
        check("rst_dat", {32'd0, wbs_dat_o}, 64'd0);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 8; i++) read_check("rst_reg", 3'(i), 32'd0);
        @(negedge wb_clk_i);
        check("ack_single", {63'd0, wbs_ack_o}, 64'd0);

        // Held valid: one ack every other cycle.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'd0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("held_valid_acks", acks, 3);

        // Loopback frame at full speed.
        run_frame("loop", 64'hDEADBEEF_01234567, 8'd0, 1'b1, 64'd0);

        // Slave-model frames: div=3 first, then random.
        for (int k = 0; k < 4; k++) begin
            tx = {$urandom, $urandom};
            run_frame("slave", tx, (k == 0) ? 8'd3 : 8'($urandom_range(0, 3)), 1'b0,
                      {$urandom, $urandom});
        end

        // Writes and a second start while busy are ignored.
        loopback = 1'b1;
        tx = {$urandom, $urandom};
        wb_write(3'd0, tx[31:0], 4'hF);
        wb_write(3'd1, tx[63:32], 4'hF);
        base = frames_done;
        wb_write(3'd4, 32'h0000_0100, 4'b0011);
        repeat (30) @(negedge wb_clk_i);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd4, 32'h0000_0105, 4'b0011);
        wait_frame(base);
        repeat (300) @(negedge wb_clk_i);
        check("busy_start_frames", frames_done, base + 1);
        check("busy_start_len", busy_len, 130);
        read_check("busy_start_rx_lo", 3'd2, tx[31:0]);
        read_check("busy_start_rx_hi", 3'd3, tx[63:32]);
        read_check("busy_tx_lo_kept", 3'd0, tx[31:0]);
        read_check("busy_div_kept", 3'd4, 32'd0);

        // Reset in the middle of a frame.
        tx = {$urandom, $urandom};
        wb_write(3'd0, tx[31:0], 4'hF);
        wb_write(3'd1, tx[63:32], 4'hF);
        wb_write(3'd4, 32'h0000_0101, 4'b0011);
        n = 0;
        while (rises < 20 && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("reach_bit20", rises >= 20, 1'b1);
        wb_rst_i = 1'b1;
        #1;
        check("midrst_cs", {63'd0, spi_cs_o}, 64'd1);
        check("midrst_sck", {63'd0, spi_sck_o}, 64'd0);
        check("midrst_busy", {63'd0, busy_o}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        read_check("midrst_rx_lo", 3'd2, 32'd0);
        read_check("midrst_rx_hi", 3'd3, 32'd0);
        read_check("midrst_status", 3'd5, 32'd0);

        // Byte-lane write.
        wb_write(3'd0, 32'hAABB_CCDD, 4'b0001);
        read_check("sel_tx_lo", 3'd0, 32'h0000_00DD);

        // Clean frame after reset with interrupt enabled, then W1C.
        tx = {$urandom, $urandom};
        wb_write(3'd0, tx[31:0], 4'hF);
        wb_write(3'd1, tx[63:32], 4'hF);
        base = frames_done;
        wb_write(3'd4, 32'h0000_0302, 4'b0011);
        wait_frame(base);
        check("irq_frame_len", busy_len, 390);
        check("irq_frame_rises", rises, 64);
        check("irq_set", {63'd0, irq_o}, 64'd1);
        read_check("irq_rx_lo", 3'd2, tx[31:0]);
        read_check("irq_rx_hi", 3'd3, tx[63:32]);
        wb_write(3'd5, 32'h0000_0002, 4'b0001);
        @(negedge wb_clk_i);
        check("irq_clear", {63'd0, irq_o}, 64'd0);
        read_check("status_cleared", 3'd5, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
